nibble_sum_accum: RTL
=====================

Name: nibble_sum_accum

Overview:
- Downstream consumer of the registered nibble-adder stage: takes its 5-bit sum (0..30) plus a valid strobe.
- Accumulates a programmable window of 1..16 samples.
- Presents total, maximum and sample count on a valid/ready result port.
- Runs in the same clock domain as the adder; all outputs are registered.

Parameters:
- SUM_W, 5, width of incoming sum.
- ACC_W, 9, accumulator/total width. Saturates at 2^ACC_W-1.
- LEN_W, 4, width of window_len; window size N = window_len+1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- sum_in  in  SUM_W  sum from adder stage
- sum_valid  in  1  sum_in carries a new sample this cycle
- window_len  in  LEN_W  window size minus one; sampled on the first sample of each window
- clear  in  1  synchronous abort/flush
- res_total  out  ACC_W  accumulated total of the window
- res_max  out  SUM_W  largest sample in the window
- res_count  out  LEN_W+1  samples in the window (= N)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- busy  out  1  window in progress (ACCUM state)
- overflow  out  1  sticky: accumulator saturated
- dropped  out  1  sticky: a sample arrived while holding a result and was discarded

Behaviour:
- Reset (async, high): state=IDLE; all outputs 0; internal acc, max, cnt and latched N are 0.
- States: IDLE, ACCUM, HOLD. Encoding is free; busy=1 only in ACCUM.
- IDLE, sum_valid=1:
  - latch N=window_len+1; acc=sum_in; max=sum_in; cnt=1.
  - If N==1, go to HOLD next cycle; else go to ACCUM.
- ACCUM, sum_valid=1:
  - acc += sum_in; max=max(max,sum_in); cnt+=1.
  - When the updated cnt==N, go to HOLD.
- ACCUM, sum_valid=0: hold all state; no timeout.
- Entering HOLD loads res_total, res_max and res_count from the final acc, max and cnt. res_valid rises the cycle after the Nth accepted sample (latency 1).
- HOLD:
  - res_* stay stable while res_valid=1 and res_ready=0.
  - sum_valid=1 with res_ready=0: discard the sample and set dropped.
- Handshake: when res_valid&&res_ready, res_valid drops next cycle.
  - Next state is IDLE.
  - Exception: if sum_valid=1 in that same cycle, the sample starts the next window (IDLE-entry rules, using window_len sampled now). Next state is ACCUM, or HOLD if N==1. It is not dropped.
- res_ready while res_valid=0 is ignored.
- Saturation: if acc+sum_in > 2^ACC_W-1, acc clamps to all-ones and overflow is set. With default widths, max 16*31=496 never saturates.
- window_len changes mid-window have no effect until the next window.
- clear=1 has highest priority after reset:
  - Next cycle: IDLE, res_valid=0, res_* = 0, overflow=0, dropped=0, acc/cnt/max = 0.
  - Any sum_valid in the clear cycle is ignored.
- Reset mid-window or mid-HOLD: immediate return to reset values; the partial window is lost.

Test Plan:
- window_len=3; samples 5,30,0,12 on consecutive cycles -> one cycle after the 4th sample: res_valid=1, res_total=47, res_max=30, res_count=4, busy=0.
- window_len=0, res_ready=1; samples 7 then 9 on consecutive cycles -> two single-sample results (total 7, then 9). The second sample, arriving in the handshake cycle, is not dropped; dropped=0.
- window_len=15, 16 samples of 31 -> res_total=496, res_count=16, overflow=0. Rerun with ACC_W=8 -> res_total=255, overflow=1.
- window_len=1, sum_valid gaps of 3 idle cycles between samples 4 and 6 -> res_total=10, res_valid exactly 1 cycle after sample 6.
- Result held with res_ready=0 for 5 cycles while samples arrive -> res_* unchanged, dropped=1. Then res_ready=1 -> res_valid=0 next cycle, state IDLE.
- Mid-window: assert clear after 2 of 4 samples -> busy=0, outputs 0 next cycle. Separately, assert reset asynchronously mid-HOLD -> res_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/nibble_sum_accum_if.sv
// Sample/result bundle between the nibble-adder stage, the window accumulator
// and the result consumer.
interface nibble_sum_accum_if #(
    parameter int SUM_W = 5,
    parameter int ACC_W = 9,
    parameter int LEN_W = 4
);
    logic [SUM_W-1:0] sum_in;
    logic             sum_valid;
    logic [LEN_W-1:0] window_len;
    logic             clear;
    logic [ACC_W-1:0] res_total;
    logic [SUM_W-1:0] res_max;
    logic [LEN_W:0]   res_count;
    logic             res_valid;
    logic             res_ready;
    logic             busy;
    logic             overflow;
    logic             dropped;

    modport master (
        output sum_in, sum_valid, window_len, clear, res_ready,
        input  res_total, res_max, res_count, res_valid, busy, overflow, dropped
    );

    modport slave (
        input  sum_in, sum_valid, window_len, clear, res_ready,
        output res_total, res_max, res_count, res_valid, busy, overflow, dropped
    );
endinterface

// File: rtl/nibble_sum_accum.sv
// Windowed accumulator for the adder-stage sums: total, maximum and count of
// 1..16 samples, presented on a valid/ready result port.
module nibble_sum_accum #(
    parameter int SUM_W = 5,
    parameter int ACC_W = 9,
    parameter int LEN_W = 4
) (
    input logic              clk,
    input logic              reset,
    nibble_sum_accum_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [SUM_W-1:0] max_r;
    logic [LEN_W:0]   cnt;
    logic [LEN_W:0]   n_len;

    logic [ACC_W-1:0] res_total;
    logic [SUM_W-1:0] res_max;
    logic [LEN_W:0]   res_count;
    logic             res_valid;
    logic             busy;
    logic             overflow;
    logic             dropped;

    // Returns {saturated, clamped sum}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
        logic [ACC_W:0] wide;
        wide = {1'b0, a} + {{(ACC_W+1-SUM_W){1'b0}}, b};
        if (wide[ACC_W])
            sat_add = {1'b1, {ACC_W{1'b1}}};
        else
            sat_add = wide;
    endfunction

    logic [LEN_W:0]   win_n;
    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W:0]   add_res;
    logic [SUM_W-1:0] max_next;
    logic [LEN_W:0]   cnt_next;
    logic             start;

    assign win_n    = {1'b0, bus.window_len} + (LEN_W+1)'(1);
    assign sum_ext  = {{(ACC_W-SUM_W){1'b0}}, bus.sum_in};
    assign add_res  = sat_add(acc, bus.sum_in);
    assign max_next = (bus.sum_in > max_r) ? bus.sum_in : max_r;
    assign cnt_next = cnt + (LEN_W+1)'(1);
    // A sample opens a new window from IDLE, or in the same cycle a held result is taken.
    assign start    = bus.sum_valid && ((state == IDLE) || (state == HOLD && bus.res_ready));

    always_ff @(posedge clk or posedge reset) begin
        if (reset || bus.clear) begin
            state     <= IDLE;
            acc       <= '0;
            max_r     <= '0;
            cnt       <= '0;
            n_len     <= '0;
            res_total <= '0;
            res_max   <= '0;
            res_count <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            dropped   <= 1'b0;
        end else if (start) begin
            n_len <= win_n;
            acc   <= sum_ext;
            max_r <= bus.sum_in;
            cnt   <= (LEN_W+1)'(1);
            if (win_n == (LEN_W+1)'(1)) begin
                state     <= HOLD;
                busy      <= 1'b0;
                res_total <= sum_ext;
                res_max   <= bus.sum_in;
                res_count <= (LEN_W+1)'(1);
                res_valid <= 1'b1;
            end else begin
                state     <= ACCUM;
                busy      <= 1'b1;
                res_valid <= 1'b0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.sum_valid) begin
                        acc   <= add_res[ACC_W-1:0];
                        max_r <= max_next;
                        cnt   <= cnt_next;
                        if (add_res[ACC_W])
                            overflow <= 1'b1;
                        if (cnt_next == n_len) begin
                            state     <= HOLD;
                            busy      <= 1'b0;
                            res_total <= add_res[ACC_W-1:0];
                            res_max   <= max_next;
                            res_count <= cnt_next;
                            res_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end else if (bus.sum_valid) begin
                        dropped <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.res_total = res_total;
    assign bus.res_max   = res_max;
    assign bus.res_count = res_count;
    assign bus.res_valid = res_valid;
    assign bus.busy      = busy;
    assign bus.overflow  = overflow;
    assign bus.dropped   = dropped;
endmodule
